// File: rtl/fighter_motion_if.sv
// fighter_motion_if: per-fighter control bundle.
//   master : frame_en, buttons (right/left/jump/squat/defend/dash), hit
//   slave  : x, y position and pose flags (isD/isQ/isJ/isDash/isHit/blocked)
interface fighter_motion_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic                 frame_en;
  logic                 right, left, jump, squat, defend, dash;
  logic                 hit;
  logic signed [XW-1:0] x;
  logic signed [YW-1:0] y;
  logic                 isD, isQ, isJ, isDash, isHit, blocked;

  modport master (
    output frame_en, right, left, jump, squat, defend, dash, hit,
    input  x, y, isD, isQ, isJ, isDash, isHit, blocked
  );

  modport slave (
    input  frame_en, right, left, jump, squat, defend, dash, hit,
    output x, y, isD, isQ, isJ, isDash, isHit, blocked
  );
endinterface

// File: rtl/fighter_motion.sv
// fighter_motion: frame-stepped motion controller for one fighter.
//   clk, rst_n : clock, async active-low reset
//   bus        : fighter_motion_if.slave -- frame_en, button levels and hit in;
//                x/y position and pose flags out
// All state advances only on frame_en. isD/isQ are combinational from state
// and the current buttons; everything else comes straight from registers.
module fighter_motion #(
  parameter int XW            = 11,
  parameter int YW            = 10,
  parameter int SIDE          = 1,
  parameter int X_MIN         = 100,
  parameter int X_MAX         = 600,
  parameter int X_INIT        = 600,
  parameter int Y_GND         = -300,
  parameter int STEP_X        = 4,
  parameter int V_JUMP        = 20,
  parameter int MAX_AIR_JUMPS = 1,
  parameter int DASH_X        = 12,
  parameter int DASH_FRAMES   = 4,
  parameter int DASH_CD       = 16,
  parameter int HIT_FRAMES    = 8,
  parameter int KNOCK_X       = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  fighter_motion_if.slave bus
);
  localparam int XE = XW + 2;   // x arithmetic width, no wrap before clamp
  localparam int YC = YW + 12;  // arc arithmetic width
  localparam int TW = $clog2(DASH_FRAMES + 1);
  localparam int CW = $clog2(DASH_CD + 1);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int AW = $clog2(MAX_AIR_JUMPS + 2);

  localparam logic signed [XE-1:0] XMIN_E  = XE'(X_MIN);
  localparam logic signed [XE-1:0] XMAX_E  = XE'(X_MAX);
  localparam logic signed [XE-1:0] STEP_E  = XE'(STEP_X);
  localparam logic signed [XE-1:0] DASH_E  = XE'(DASH_X);
  localparam logic signed [XE-1:0] KNOCK_E = XE'(KNOCK_X);
  localparam logic signed [YC-1:0] YGND_E  = YC'(Y_GND);
  localparam logic signed [YC-1:0] VJ_E    = YC'(V_JUMP);

  typedef enum logic [1:0] {M_NORMAL, M_DASH, M_HIT} mode_t;
  typedef enum logic {V_GND, V_AIR} vert_t;

  mode_t                mode;
  vert_t                vert;
  logic signed [XW-1:0] x;
  logic signed [YW-1:0] y, base;
  logic [7:0]           n;
  logic [AW-1:0]        air_cnt;
  logic [TW-1:0]        dash_tmr;
  logic [CW-1:0]        cd;
  logic [HW-1:0]        hit_tmr;
  logic                 dash_dir;  // 1 = +x
  logic                 jump_q;
  logic                 blocked;

  logic                 jump_rise, on_gnd, hit_take, hit_blk, dash_go, jump_ok;
  logic signed [XE-1:0] dx, x_sum, x_nxt;
  logic [8:0]           n1;
  logic signed [YC-1:0] nn, base_e, yc;
  logic                 land;

  always_comb begin
    jump_rise = bus.jump & ~jump_q;
    on_gnd    = (vert == V_GND);
    // defend only absorbs a hit with both feet on the floor
    hit_blk   = bus.hit & bus.defend & on_gnd;
    hit_take  = bus.hit & ~hit_blk;
    dash_go   = (mode == M_NORMAL) & bus.dash & (cd == '0) & ~bus.defend & ~hit_take;
    jump_ok   = jump_rise & (mode != M_HIT) & ~hit_take;

    // The frame that enters HIT or DASH does not move; an ongoing HIT keeps
    // knocking back even when re-hit.
    dx = '0;
    if (mode == M_HIT)
      dx = (SIDE != 0) ? KNOCK_E : -KNOCK_E;
    else if (hit_take)
      dx = '0;
    else if (mode == M_DASH)
      dx = dash_dir ? DASH_E : -DASH_E;
    else if (!dash_go && !bus.defend) begin
      if (bus.right)     dx = STEP_E;
      else if (bus.left) dx = -STEP_E;
    end
    x_sum = XE'(x) + dx;
    if (x_sum > XMAX_E)      x_nxt = XMAX_E;
    else if (x_sum < XMIN_E) x_nxt = XMIN_E;
    else                     x_nxt = x_sum;

    // arc: base + V*n' - n'^2, landing always tested against ground
    n1     = {1'b0, n} + 9'd1;
    nn     = $signed({{(YC-9){1'b0}}, n1});
    base_e = YC'(base);
    yc     = base_e + VJ_E * nn - nn * nn;
    land   = (yc < YGND_E) || (n == 8'd255);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= M_NORMAL;
      vert     <= V_GND;
      x        <= XW'(X_INIT);
      y        <= YW'(Y_GND);
      base     <= YW'(Y_GND);
      n        <= '0;
      air_cnt  <= '0;
      dash_tmr <= '0;
      cd       <= '0;
      hit_tmr  <= '0;
      dash_dir <= 1'b0;
      jump_q   <= 1'b0;
      blocked  <= 1'b0;
    end else if (bus.frame_en) begin
      jump_q  <= bus.jump;
      blocked <= hit_blk;
      x       <= x_nxt[XW-1:0];
      if (cd != '0) cd <= cd - CW'(1);

      // horizontal mode: hit > dash start > walk
      if (hit_take) begin
        mode    <= M_HIT;
        hit_tmr <= HW'(HIT_FRAMES);
        if (mode == M_DASH) cd <= CW'(DASH_CD);
      end else begin
        case (mode)
          M_HIT: begin
            hit_tmr <= hit_tmr - HW'(1);
            if (hit_tmr <= HW'(1)) mode <= M_NORMAL;
          end
          M_DASH: begin
            dash_tmr <= dash_tmr - TW'(1);
            if (dash_tmr <= TW'(1)) begin
              mode <= M_NORMAL;
              cd   <= CW'(DASH_CD);
            end
          end
          default: if (dash_go) begin
            mode     <= M_DASH;
            dash_tmr <= TW'(DASH_FRAMES);
            dash_dir <= bus.right ? 1'b1 : bus.left ? 1'b0 : (SIDE == 0);
          end
        endcase
      end

      // vertical
      if (vert == V_GND) begin
        y <= YW'(Y_GND);
        if (jump_ok) begin
          vert    <= V_AIR;
          base    <= YW'(Y_GND);
          n       <= '0;
          air_cnt <= '0;
        end
      end else if (jump_ok && air_cnt < AW'(MAX_AIR_JUMPS)) begin
        base    <= y;  // new arc starts from the current height
        n       <= '0;
        air_cnt <= air_cnt + AW'(1);
      end else if (land) begin
        y    <= YW'(Y_GND);
        vert <= V_GND;
      end else begin
        y <= yc[YW-1:0];
        n <= n1[7:0];
      end
    end
  end

  assign bus.x       = x;
  assign bus.y       = y;
  assign bus.isJ     = (vert == V_AIR);
  assign bus.isDash  = (mode == M_DASH);
  assign bus.isHit   = (mode == M_HIT);
  assign bus.blocked = blocked;
  assign bus.isQ     = bus.squat & (vert == V_GND) & (mode == M_NORMAL);
  assign bus.isD     = bus.defend & (mode != M_HIT);
endmodule

// File: tb/tb_fighter_motion.sv
// tb_fighter_motion: directed vectors for fighter_motion with default
// parameters (SIDE=1, x starts at 600, ground at -300).
module tb_fighter_motion;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fighter_motion_if #(.XW(11), .YW(10)) bus ();
  fighter_motion dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // button word {right,left,jump,squat,defend,dash,hit}
  localparam logic [6:0] B0 = 7'b0000000, R = 7'b1000000, L = 7'b0100000,
                         J = 7'b0010000, Q = 7'b0001000, D = 7'b0000100,
                         DS = 7'b0000010, H = 7'b0000001;
  // flag word {isD,isQ,isJ,isDash,isHit,blocked}
  localparam logic [5:0] F0 = 6'b000000, FD = 6'b100000, FQ = 6'b010000,
                         FJ = 6'b001000, FDS = 6'b000100, FH = 6'b000010,
                         FB = 6'b000001;

  typedef struct {
    logic [6:0] b;
    int         ex;
    int         ey;
    logic [5:0] ef;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int ex, input int ey, input logic [5:0] ef);
    int ax, ay;
    logic [5:0] af;
    ax = $signed(bus.x);
    ay = $signed(bus.y);
    af = {bus.isD, bus.isQ, bus.isJ, bus.isDash, bus.isHit, bus.blocked};
    nvec += 3;
    if (ax != ex) begin nerr++; $display("FAIL %s x got %0d want %0d", nm, ax, ex); end
    if (ay != ey) begin nerr++; $display("FAIL %s y got %0d want %0d", nm, ay, ey); end
    if (af != ef) begin nerr++; $display("FAIL %s flags got %b want %b", nm, af, ef); end
  endtask

  task automatic frame(input logic [6:0] b);
    {bus.right, bus.left, bus.jump, bus.squat, bus.defend, bus.dash, bus.hit} = b;
    bus.frame_en = 1'b1;
    @(negedge clk);
    bus.frame_en = 1'b0;
  endtask

  function automatic int arc(input int base, input int k);
    return base + 20 * k - k * k;
  endfunction

  vec_t tbl[9];

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{L,      596, -300, F0};
    tbl[1] = '{L,      592, -300, F0};
    tbl[2] = '{R | L,  596, -300, F0};
    tbl[3] = '{R,      600, -300, F0};
    tbl[4] = '{R,      600, -300, F0};
    tbl[5] = '{D | L,  600, -300, FD};
    tbl[6] = '{Q,      600, -300, FQ};
    tbl[7] = '{D | H,  600, -300, FD | FB};
    tbl[8] = '{B0,     600, -300, F0};

    rst_n = 1'b0;
    bus.frame_en = 1'b0;
    {bus.right, bus.left, bus.jump, bus.squat, bus.defend, bus.dash, bus.hit} = B0;
    repeat (3) @(negedge clk);
    chk("reset", 600, -300, F0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin frame(B0); chk("idle", 600, -300, F0); end

    for (int i = 0; i < 9; i++) begin
      frame(tbl[i].b);
      chk($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ef);
    end

    // no motion without frame_en
    {bus.right, bus.left} = 2'b10;
    repeat (5) @(negedge clk);
    chk("hold_no_fen", 600, -300, F0);

    // walk to 500, take a hit, walk input ignored during stun
    for (int k = 1; k <= 25; k++) frame(L);
    chk("walk500", 500, -300, F0);
    frame(L | H);
    chk("hit0", 500, -300, FH);
    for (int k = 1; k <= 8; k++) begin
      frame(L);
      chk($sformatf("knock%0d", k), 500 + 6 * k, -300, (k < 8) ? FH : F0);
    end

    // knockback clamps at X_MAX
    for (int k = 1; k <= 10; k++) frame(R);
    chk("walk588", 588, -300, F0);
    frame(H);
    chk("hit1", 588, -300, FH);
    for (int k = 1; k <= 8; k++) begin
      frame(B0);
      chk($sformatf("knockc%0d", k), (588 + 6 * k > 600) ? 600 : 588 + 6 * k, -300,
          (k < 8) ? FH : F0);
    end

    // dash forward (-x), held: cooldown of 16 frames before the next one
    frame(DS);
    chk("dash0", 600, -300, FDS);
    for (int k = 1; k <= 25; k++) begin
      int ex;
      logic [5:0] ef;
      frame(DS);
      if (k <= 4)       begin ex = 600 - 12 * k;        ef = (k < 4) ? FDS : F0; end
      else if (k <= 20) begin ex = 552;                 ef = F0; end
      else if (k == 21) begin ex = 552;                 ef = FDS; end
      else              begin ex = 552 - 12 * (k - 21); ef = (k < 25) ? FDS : F0; end
      chk($sformatf("dash%0d", k), ex, -300, ef);
    end

    // dash into X_MIN clamps
    for (int k = 1; k <= 98; k++) frame(L);
    chk("walk112", 112, -300, F0);
    frame(DS);
    chk("dashm0", 112, -300, FDS);
    for (int k = 1; k <= 4; k++) begin
      frame(B0);
      chk($sformatf("dashm%0d", k), 100, -300, (k < 4) ? FDS : F0);
    end

    // single jump, jump held throughout: no re-jump after landing
    frame(J);
    chk("jump0", 100, -300, FJ);
    for (int k = 1; k <= 22; k++) begin
      frame(J);
      chk($sformatf("arc%0d", k), 100, (k <= 20) ? arc(-300, k) : -300,
          (k <= 20) ? FJ : F0);
    end
    frame(B0);

    // double jump at n=5, third press ignored
    frame(J);
    chk("dj0", 100, -300, FJ);
    for (int k = 1; k <= 5; k++) begin
      frame(B0);
      chk($sformatf("dja%0d", k), 100, arc(-300, k), FJ);
    end
    frame(J);
    chk("dj_air", 100, -225, FJ);
    for (int m = 1; m <= 24; m++) begin
      frame((m == 3) ? B0 : J);
      chk($sformatf("djb%0d", m), 100, (m < 24) ? arc(-225, m) : -300,
          (m < 24) ? FJ : F0);
    end
    frame(B0);

    // async reset at the apex
    frame(J);
    for (int k = 1; k <= 10; k++) frame(B0);
    chk("apex", 100, -200, FJ);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 600, -300, F0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fighter_motion.md
Name: fighter_motion

Overview:
- Parametrised per-fighter motion controller for the game-control layer; one instance per side (player, enemy).
- Turns debounced button levels into frame-stepped x/y position and pose flags for the renderer and hit logic.
- Adds over the previous per-side controllers:
  - frame-enable stepping
  - configurable arena bounds
  - multi-jump with edge detect
  - timed dash with cooldown
  - hit-stun knockback with blocking

Parameters:
- XW, 11, signed width of x
- YW, 10, signed width of y
- SIDE, 1, 0 = left fighter (forward is +x), 1 = right fighter (forward is -x)
- X_MIN, 100, lowest legal x
- X_MAX, 600, highest legal x
- X_INIT, 600, x after reset
- Y_GND, -300, ground y (feet on floor)
- STEP_X, 4, walk displacement per frame
- V_JUMP, 20, jump velocity term; V_JUMP*V_JUMP/4 + Y_GND must fit in YW
- MAX_AIR_JUMPS, 1, extra jumps allowed while airborne
- DASH_X, 12, dash displacement per frame
- DASH_FRAMES, 4, dash length in frames
- DASH_CD, 16, frames after a dash ends before the next dash may start
- HIT_FRAMES, 8, hit-stun length in frames
- KNOCK_X, 6, knockback displacement per frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_en  in  1  one-cycle pulse; all state advances only on cycles with frame_en=1
- right, left, jump, squat, defend, dash  in  1 each  button levels
- hit  in  1  level, sampled on frame_en; opponent attack connected this frame
- x  out  XW  signed x position
- y  out  YW  signed y position
- isD  out  1  defending
- isQ  out  1  squatting
- isJ  out  1  airborne
- isDash  out  1  dashing
- isHit  out  1  in hit-stun
- blocked  out  1  one-frame pulse (held until next frame_en): a hit was absorbed by defend

Behaviour:
- Reset (async, rst_n=0):
  - x=X_INIT, y=Y_GND
  - mode=NORMAL, vertical=GROUND
  - jump counter, air-jump count, dash timer, cooldown, hit timer all 0
  - jump_q=0, blocked=0, all flags 0
- Registers hold whenever frame_en=0. Outputs are registered, except isD and isQ, which are combinational from registered state and current inputs.
- Horizontal modes: NORMAL, DASH, HIT. Priority on a frame: hit > dash start > walk.
- Hit handling:
  - If defend=1 and GROUND: hit is blocked. Pulse blocked=1; mode is unchanged.
  - Otherwise: mode=HIT, hit timer=HIT_FRAMES, any dash is aborted (cooldown=DASH_CD).
  - A hit while already in HIT reloads the timer.
- HIT mode:
  - Each frame x moves KNOCK_X backward: -x for SIDE 0, +x for SIDE 1.
  - Timer decrements; on reaching 0, mode returns to NORMAL at the next frame.
  - Walk, dash, jump and squat are ignored. An airborne arc continues.
- Dash start: requires NORMAL, dash=1, cooldown=0, defend=0.
  - Direction: right if right=1, else left if left=1, else forward.
  - Latch the direction; timer=DASH_FRAMES.
- DASH mode:
  - x moves DASH_X per frame in the latched direction.
  - On the last frame, mode returns to NORMAL and cooldown=DASH_CD. Cooldown decrements on every frame while nonzero.
- Walk: in NORMAL with defend=0, right wins over left and moves ±STEP_X. When both are 0, x holds.
- x clamp: after every update x is saturated to [X_MIN, X_MAX]. Intermediate arithmetic uses XW+2 bits, so there is no wrap.
- Jump detection: jump_rise = jump & ~jump_q. jump_q updates on frame_en only.
- GROUND state:
  - jump_rise and mode≠HIT: go AIR, base=Y_GND, n=0, air-jump count=0, y=Y_GND on this frame.
  - Otherwise y=Y_GND.
- AIR state, each frame:
  - n'=n+1
  - yc = base + V_JUMP*n' - n'*n', computed in YW+12 signed
  - If yc < Y_GND: y=Y_GND, go GROUND.
  - Else: y=yc, n=n'.
  - n saturating at 255 forces landing.
- Air jump: in AIR, jump_rise, mode≠HIT and air-jump count < MAX_AIR_JUMPS:
  - base = current y, n=0, count+1, y holds this frame.
  - Landing is always tested against Y_GND, not base.
- Pose flags:
  - isJ = AIR
  - isQ = squat & GROUND & mode=NORMAL
  - isD = defend & mode≠HIT
  - isDash = mode=DASH
  - isHit = mode=HIT
- Simultaneous events:
  - jump_rise with dash start: both take effect.
  - hit with jump_rise: hit wins, no jump.
  - Landing and the hit timer expiring on the same frame: both take effect.

Test Plan:
- Reset, then no input for 10 frames -> x=600, y=-300, all flags 0. Assert rst_n low mid-jump (y=-200) -> asynchronously x=600, y=-300, isJ=0.
- Single jump with defaults:
  - Pulse jump for 1 frame -> isJ=1.
  - y sequence -300, -281, -264, …; apex -200 at n=10; y=-300 at n=20.
  - Landing at n=21: isJ=0.
  - Holding jump high does not re-jump.
- Double jump:
  - At n=5 (y=-225), release then press jump -> new arc from -225: next y = -225+19 = -206.
  - A third press in air is ignored.
  - Lands at Y_GND.
- Dash:
  - From x=600, SIDE=1, no direction -> x = 588, 576, 564, 552, then isDash=0.
  - dash held -> next dash only after 16 frames.
  - Dash toward X_MIN clamps at 100.
- Hit:
  - hit with defend=0 at x=500 -> isHit=1 for 8 frames, x rises 6/frame, clamped at 600; walk ignored.
  - Same hit with defend=1 on ground -> blocked=1 for one frame, x unchanged.
- Walk and bounds: right+left together -> +4/frame; walk held to X_MAX saturates at 600; no motion when frame_en=0.
